// File: rtl/gpi_seq_pkg.sv
// rtl/gpi_seq_pkg.sv - shared state encoding for the GPI pattern sequencer
package gpi_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    localparam int SEQ_STATE_W = 2;

endpackage

// File: rtl/gpi_tick_gen.sv
// rtl/gpi_tick_gen.sv - clock-enable prescaler; tick is high for one clk every PRESCALE clks
module gpi_tick_gen #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/gpi_pattern_sequencer.sv
// rtl/gpi_pattern_sequencer.sv - steps the GPI bus through a programmable (value, hold) table
module gpi_pattern_sequencer
    import gpi_seq_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int DUR_W    = 16,
    parameter int PRESCALE = 4,
    parameter logic [DATA_W-1:0] IDLE_VAL = '0,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [DATA_W-1:0] cfg_value,
    input  logic [DUR_W-1:0]  cfg_hold,
    input  logic [AW-1:0]     seq_last,
    input  logic              loop_en,
    input  logic              start,
    input  logic              stop,
    output logic [DATA_W-1:0] gpi,
    output logic              busy,
    output logic [AW-1:0]     step_idx,
    output logic              step_pulse,
    output logic              done
);

    logic [DATA_W-1:0] tbl_value [DEPTH];
    logic [DUR_W-1:0]  tbl_hold  [DEPTH];

    seq_state_t        state;
    logic [AW-1:0]     last;
    logic [DUR_W-1:0]  remain;
    logic [AW-1:0]     nxt_idx;
    logic              accept;
    logic              tick;

    // A zero hold still drives the entry for one tick.
    function automatic logic [DUR_W-1:0] eff_hold(input logic [DUR_W-1:0] h);
        return (h == '0) ? DUR_W'(1) : h;
    endfunction

    assign accept  = (state != ST_HOLD) && start && !stop;
    assign nxt_idx = step_idx + AW'(1);

    gpi_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .tick  (tick)
    );

    // Writes commit at the edge, so a reload in the same cycle sees the old entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_value[i] <= '0;
                tbl_hold[i]  <= '0;
            end
        end else if (cfg_we) begin
            tbl_value[cfg_addr] <= cfg_value;
            tbl_hold[cfg_addr]  <= cfg_hold;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            gpi        <= IDLE_VAL;
            busy       <= 1'b0;
            done       <= 1'b0;
            step_pulse <= 1'b0;
            step_idx   <= '0;
            last       <= '0;
            remain     <= '0;
        end else begin
            done       <= 1'b0;
            step_pulse <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (stop) begin
                        state    <= ST_IDLE;
                        gpi      <= IDLE_VAL;
                        busy     <= 1'b0;
                        step_idx <= '0;
                    end else if (start) begin
                        state      <= ST_HOLD;
                        last       <= seq_last;
                        step_idx   <= '0;
                        gpi        <= tbl_value[0];
                        remain     <= eff_hold(tbl_hold[0]);
                        step_pulse <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (stop) begin
                        state    <= ST_IDLE;
                        gpi      <= IDLE_VAL;
                        busy     <= 1'b0;
                        step_idx <= '0;
                    end else if (tick) begin
                        if (remain > DUR_W'(1)) begin
                            remain <= remain - DUR_W'(1);
                        end else if (step_idx < last) begin
                            step_idx   <= nxt_idx;
                            gpi        <= tbl_value[nxt_idx];
                            remain     <= eff_hold(tbl_hold[nxt_idx]);
                            step_pulse <= 1'b1;
                        end else if (loop_en) begin
                            step_idx   <= '0;
                            gpi        <= tbl_value[0];
                            remain     <= eff_hold(tbl_hold[0]);
                            step_pulse <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gpi   <= IDLE_VAL;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpi_pattern_sequencer.sv
// tb/tb_gpi_pattern_sequencer.sv - directed self-checking bench for gpi_pattern_sequencer
module tb_gpi_pattern_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_value;
    logic [15:0] cfg_hold;
    logic [1:0]  seq_last;
    logic        loop_en;
    logic        start;
    logic        stop;
    logic [7:0]  gpi;
    logic        busy;
    logic [1:0]  step_idx;
    logic        step_pulse;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    gpi_pattern_sequencer #(
        .DATA_W   (8),
        .DEPTH    (4),
        .DUR_W    (16),
        .PRESCALE (4),
        .IDLE_VAL (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_value  (cfg_value),
        .cfg_hold   (cfg_hold),
        .seq_last   (seq_last),
        .loop_en    (loop_en),
        .start      (start),
        .stop       (stop),
        .gpi        (gpi),
        .busy       (busy),
        .step_idx   (step_idx),
        .step_pulse (step_pulse),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] v, input logic [15:0] h);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_value = v;
        cfg_hold  = h;
        step();
        cfg_we    = 1'b0;
    endtask

    // Entry must show val with busy set for exactly n samples, pulse only on the first.
    task automatic hold_check(input string tag, input logic [7:0] val, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (gpi !== val || busy !== 1'b1 || done !== 1'b0) bad++;
            if (i > 0 && step_pulse !== 1'b0) bad++;
            step();
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_value = '0; cfg_hold = '0;
        seq_last = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;

        // 1: reset
        step(); step();
        chk("rst_gpi", gpi, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pulse", step_pulse, 0);
        chk("rst_idx", step_idx, 0);
        rst_n = 1'b1;
        step();

        // 2: two-entry one-shot
        wr(2'd0, 8'h01, 16'd2);
        wr(2'd1, 8'h02, 16'd3);
        seq_last = 2'd1; loop_en = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("os_pulse0", step_pulse, 1);
        chk("os_idx0", step_idx, 0);
        hold_check("os_e0_8clk", 8'h01, 8);
        chk("os_pulse1", step_pulse, 1);
        chk("os_idx1", step_idx, 1);
        hold_check("os_e1_12clk", 8'h02, 12);
        chk("os_done", done, 1);
        chk("os_busy_fall", busy, 0);
        chk("os_gpi_keep", gpi, 8'h02);
        step();
        chk("os_done_1cyc", done, 0);
        chk("os_gpi_keep2", gpi, 8'h02);

        // 3: four-entry loop, restart from DONE
        wr(2'd0, 8'h00, 16'd200);
        wr(2'd1, 8'h01, 16'd200);
        wr(2'd2, 8'h02, 16'd200);
        wr(2'd3, 8'h01, 16'd200);
        seq_last = 2'd3; loop_en = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        hold_check("lp_e0", 8'h00, 800);
        hold_check("lp_e1", 8'h01, 800);
        hold_check("lp_e2", 8'h02, 800);
        chk("lp_idx3", step_idx, 3);
        hold_check("lp_e3", 8'h01, 800);
        chk("lp_wrap_pulse", step_pulse, 1);
        chk("lp_wrap_idx", step_idx, 0);
        chk("lp_wrap_gpi", gpi, 8'h00);

        // 4: stop mid-entry 1, then start+stop together
        hold_check("lp_e0b", 8'h00, 800);
        chk("st_e1_gpi", gpi, 8'h01);
        for (int i = 0; i < 10; i++) step();
        stop = 1'b1; step(); stop = 1'b0;
        chk("st_gpi_idle", gpi, 8'h00);
        chk("st_busy", busy, 0);
        chk("st_no_done", done, 0);
        step();
        chk("st_no_done2", done, 0);
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        chk("ss_busy", busy, 0);
        chk("ss_pulse", step_pulse, 0);
        step();
        chk("ss_still_idle", busy, 0);

        // 5: zero hold and live rewrite of the active entry
        wr(2'd0, 8'h5A, 16'd0);
        wr(2'd1, 8'h33, 16'd1);
        seq_last = 2'd1; loop_en = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        hold_check("h0_4clk", 8'h5A, 4);
        chk("rw_gpi_cur", gpi, 8'h33);
        wr(2'd1, 8'h77, 16'd1);
        hold_check("rw_unchanged", 8'h33, 3);
        hold_check("rw_e0_again", 8'h5A, 4);
        chk("rw_new_val", gpi, 8'h77);
        chk("rw_new_pulse", step_pulse, 1);

        // 6: reset mid-HOLD, then clean restart on a cleared table
        step();
        rst_n = 1'b0; step();
        chk("mr_gpi", gpi, 8'h00);
        chk("mr_busy", busy, 0);
        chk("mr_idx", step_idx, 0);
        chk("mr_pulse", step_pulse, 0);
        chk("mr_done", done, 0);
        rst_n = 1'b1; step();
        seq_last = 2'd0; loop_en = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("rs_pulse", step_pulse, 1);
        hold_check("rs_cleared_e0", 8'h00, 4);
        chk("rs_done", done, 1);
        chk("rs_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
